// File: rtl/dispatch_front.sv
// In-order dispatch front end: pops the IFQ into a single dispatch register and
// redirects on J/JAL or taken BEQ/BNE. Optional statistics counters: DISPATCH_STATS_EN.
module dispatch_front (
    input  logic        clk,
    input  logic        rst,
    input  logic        empty,
    input  logic [31:0] inst,
    input  logic [31:0] pc_out,
    output logic        inst_rd_en,
    output logic [31:0] jmp_branch_address,
    output logic        jmp_branch_valid,
    input  logic        br_resolve_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [31:0] disp_inst,
    output logic [31:0] disp_pc
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0] disp_count,
    output logic [15:0] redirect_count
`endif
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_WAIT_BR = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        disp_valid_q, disp_valid_d;
    logic [31:0] disp_inst_q, disp_inst_d;
    logic [31:0] disp_pc_q, disp_pc_d;
    logic        jbv_q, jbv_d;
    logic [31:0] jba_q, jba_d;

    logic        pop;
    logic [5:0]  opcode;
    logic        is_jump;
    logic        is_branch;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;

    // The dispatch slot is free when empty or being drained this cycle.
    assign pop = !rst && (state_q == ST_RUN) && !empty && (!disp_valid_q || disp_ready);

    assign opcode      = inst[31:26];
    assign is_jump     = (opcode == 6'b000010) || (opcode == 6'b000011);
    assign is_branch   = (opcode == 6'b000100) || (opcode == 6'b000101);
    assign pc_plus4    = pc_out + 32'd4;
    assign jump_target = (pc_plus4 & 32'hF000_0000) | {4'b0000, inst[25:0], 2'b00};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        jbv_d        = 1'b0;
        jba_d        = jba_q;
        disp_valid_d = disp_valid_q;
        disp_inst_d  = disp_inst_q;
        disp_pc_d    = disp_pc_q;

        if (pop) begin
            disp_valid_d = 1'b1;
            disp_inst_d  = inst;
            disp_pc_d    = pc_out;
        end else if (disp_ready) begin
            disp_valid_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (pop && is_jump) begin
                    state_d = ST_FLUSH;
                    jbv_d   = 1'b1;
                    jba_d   = jump_target;
                end else if (pop && is_branch) begin
                    state_d = ST_WAIT_BR;
                end
            end
            ST_WAIT_BR: begin
                if (br_resolve_valid) begin
                    if (br_taken) begin
                        state_d = ST_FLUSH;
                        jbv_d   = 1'b1;
                        jba_d   = br_target;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= ST_RUN;
            disp_valid_q <= 1'b0;
            disp_inst_q  <= 32'd0;
            disp_pc_q    <= 32'd0;
            jbv_q        <= 1'b0;
            jba_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            disp_valid_q <= disp_valid_d;
            disp_inst_q  <= disp_inst_d;
            disp_pc_q    <= disp_pc_d;
            jbv_q        <= jbv_d;
            jba_q        <= jba_d;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] disp_count_q;
    logic [15:0] redirect_count_q;

    // Redirects are counted on the edge that raises the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_count_q     <= 32'd0;
            redirect_count_q <= 16'd0;
        end else begin
            if (pop)   disp_count_q     <= disp_count_q + 32'd1;
            if (jbv_d) redirect_count_q <= redirect_count_q + 16'd1;
        end
    end

    assign disp_count     = disp_count_q;
    assign redirect_count = redirect_count_q;
`endif

    assign inst_rd_en         = pop;
    assign jmp_branch_valid   = jbv_q;
    assign jmp_branch_address = jba_q;
    assign disp_valid         = disp_valid_q;
    assign disp_inst          = disp_inst_q;
    assign disp_pc            = disp_pc_q;

endmodule

// File: doc/dispatch_front.md
DISPATCH_FRONT -- requirements
Module: dispatch_front

Interface
REQ-001 The interface SHALL have one clock; reset is synchronous and active-high. Ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 empty  input  1  IFQ has no valid instruction.
REQ-005 inst  input  32  IFQ head instruction, valid when empty=0.
REQ-006 pc_out  input  32  PC of IFQ head instruction.
REQ-007 inst_rd_en  output  1  pop IFQ head this cycle.
REQ-008 jmp_branch_address  output  32  redirect target to IFQ.
REQ-009 jmp_branch_valid  output  1  one-cycle redirect/flush strobe to IFQ.
REQ-010 br_resolve_valid  input  1  branch unit resolution strobe.
REQ-011 br_taken  input  1  resolved branch outcome, qualified by br_resolve_valid.
REQ-012 br_target  input  32  resolved taken target, qualified by br_resolve_valid.
REQ-013 disp_valid  output  1  dispatch output register holds an instruction.
REQ-014 disp_ready  input  1  downstream accepts disp_inst/disp_pc this cycle.
REQ-015 disp_inst  output  32  dispatched instruction.
REQ-016 disp_pc  output  32  PC of dispatched instruction.

Function
REQ-017 States SHALL be RUN, WAIT_BR, FLUSH, encoded in a registered state variable.
REQ-018 inst_rd_en SHALL be combinational: 1 only when state=RUN, empty=0, and (disp_valid=0 or disp_ready=1).
REQ-019 On a pop, inst/pc_out SHALL load into disp_inst/disp_pc with disp_valid=1 on the next edge (latency 1 cycle).
REQ-020 disp_valid SHALL clear on the edge where disp_ready=1 and no pop occurs; disp_inst/disp_pc SHALL hold while disp_valid=1 and disp_ready=0.
REQ-021 Popped opcode inst[31:26]=000010 (J) or 000011 (JAL): jmp_branch_valid=1 next cycle, jmp_branch_address={pc_out+4 [31:28], inst[25:0], 2'b00} (32-bit wrap), state -> FLUSH.
REQ-022 Popped opcode 000100 (BEQ) or 000101 (BNE): state -> WAIT_BR; no further pops until resolved.
REQ-023 WAIT_BR with br_resolve_valid=1, br_taken=1: jmp_branch_valid=1 next cycle with address=br_target, state -> FLUSH.
REQ-024 WAIT_BR with br_resolve_valid=1, br_taken=0: state -> RUN, no redirect.
REQ-025 FLUSH SHALL last exactly one cycle with inst_rd_en=0, then -> RUN.
REQ-026 br_resolve_valid in RUN or FLUSH SHALL be ignored.
REQ-027 jmp_branch_valid SHALL be a registered single-cycle pulse; jmp_branch_address SHALL hold its last value otherwise.
REQ-028 The jump/branch instruction itself SHALL still be dispatched via disp_* like any other.
REQ-029 Resolution arriving in the same cycle the branch is popped SHALL be ignored; resolution counts only from WAIT_BR.

Reset
REQ-030 rst=1 at a clock edge SHALL force state=RUN, disp_valid=0, disp_inst=0, disp_pc=0, jmp_branch_valid=0, jmp_branch_address=0, and all counters to 0.
REQ-031 inst_rd_en SHALL be 0 during any cycle with rst=1.
REQ-032 Reset asserted during WAIT_BR or FLUSH SHALL discard the pending branch/flush with no redirect pulse.

Configuration
REQ-033 Macro DISPATCH_STATS_EN SHALL add outputs disp_count[31:0] (increments per pop) and redirect_count[15:0] (increments per jmp_branch_valid pulse), both wrapping at max.
REQ-034 Without DISPATCH_STATS_EN those ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-035 Reset then IFQ holding 4 ALU ops, disp_ready=1 -> 4 consecutive pops, disp_valid 1 cycle after each, disp_pc 0x0,0x4,0x8,0xC.
REQ-036 disp_ready=0 with disp_valid=1, empty=0 -> inst_rd_en=0 and disp_* stable until disp_ready=1.
REQ-037 Pop J inst=0x08000040 at pc_out=0x00000010 -> next cycle jmp_branch_valid=1, address=0x00000100; one FLUSH cycle with no pop.
REQ-038 Pop BEQ at 0x20, then br_resolve_valid=1, br_taken=1, br_target=0x80 after 3 cycles -> no pops in between, redirect to 0x80, then FLUSH, RUN.
REQ-039 Pop BNE, resolve br_taken=0 -> no jmp_branch_valid, pops resume next cycle.
REQ-040 Assert rst during WAIT_BR -> all outputs at reset values, state RUN, no redirect; with DISPATCH_STATS_EN, counters read 0.
